// File: rtl/note_spawn_scheduler.sv
// note_spawn_scheduler
//
// Walks the note-chart ROM in order. For each note it issues one spawn event
// LEAD_FRAMES frames before the note's hit time. It sits directly after the
// song frame timer.
//
// Ports:
//   clk             system clock, all logic on posedge
//   reset           synchronous, active-low reset
//   start_sign      song start: restarts the chart walk from index 0
//   new_frame       frame strobe (level); a rising edge marks a new frame
//   un_time[15:0]   current song frame count from the timer
//   stop_sign       song finished: ends the walk from any busy state
//   rom_addr        chart ROM read address (1-cycle read latency)
//   rom_data[19:0]  chart word: [19:4] hit_time, [3:2] lane, [1:0] type;
//                   a hit_time of 16'hFFFF marks the end of the chart
//   spawn_valid     spawn event valid (valid/ready handshake)
//   spawn_ready     downstream accepts the event
//   spawn_hit_time  hit frame of the spawned note
//   spawn_lane      lane of the spawned note
//   spawn_type      type of the spawned note
//   notes_spawned   number of accepted spawns since start
//   chart_done      high in DONE
//   busy            high in any state except IDLE and DONE
module note_spawn_scheduler #(
   parameter int LEAD_FRAMES = 120,
   parameter int ADDR_W      = 10,
   parameter int MAX_NOTES   = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_sign,
   input  logic              new_frame,
   input  logic [15:0]       un_time,
   input  logic              stop_sign,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [19:0]       rom_data,
   output logic              spawn_valid,
   input  logic              spawn_ready,
   output logic [15:0]       spawn_hit_time,
   output logic [1:0]        spawn_lane,
   output logic [1:0]        spawn_type,
   output logic [ADDR_W:0]   notes_spawned,
   output logic              chart_done,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOAD,
      S_CHECK,
      S_ARMED,
      S_EMIT,
      S_DONE
   } state_t;

   localparam logic [16:0]   LEAD17  = 17'(LEAD_FRAMES);
   localparam logic [ADDR_W:0] MAX_IDX = (ADDR_W + 1)'(MAX_NOTES);

   state_t              state_reg, state_next;
   logic                new_frame_q_reg;
   logic [15:0]         ft_reg;
   logic                have_frame_reg;
   logic [ADDR_W-1:0]   idx_reg;
   logic [ADDR_W:0]     notes_reg;
   logic [15:0]         cur_hit_reg;
   logic [1:0]          cur_lane_reg;
   logic [1:0]          cur_type_reg;
   logic                spawn_valid_reg;
   logic                chart_done_reg;
   logic                busy_reg;

   logic fe;
   logic handshake;
   logic due;
   logic is_end;
   logic state_busy;
   logic restart;

   assign fe         = new_frame & ~new_frame_q_reg;
   // spawn_valid_reg is high only while in EMIT, so this is an EMIT handshake
   assign handshake  = spawn_valid_reg & spawn_ready;
   // 17-bit compare so ft + LEAD never wraps past 16'hFFFF
   assign due        = have_frame_reg &&
                       (({1'b0, ft_reg} + LEAD17) >= {1'b0, cur_hit_reg});
   assign is_end     = (rom_data[19:4] == 16'hFFFF) || ({1'b0, idx_reg} == MAX_IDX);
   assign state_busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign restart    = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && start_sign;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start_sign) state_next = S_FETCH;
         S_FETCH: state_next = S_WAIT;
         S_WAIT:  state_next = S_LOAD;
         S_LOAD:  state_next = is_end ? S_DONE : S_CHECK;
         S_CHECK: state_next = due ? S_EMIT : S_ARMED;
         S_ARMED: if (fe) state_next = S_CHECK;
         S_EMIT:  if (handshake) state_next = S_FETCH;
         S_DONE:  if (start_sign) state_next = S_FETCH;
         default: state_next = S_IDLE;
      endcase
      // stop_sign overrides every normal transition out of a busy state
      if (state_busy && stop_sign) state_next = S_DONE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         new_frame_q_reg <= 1'b0;
         ft_reg          <= '0;
         have_frame_reg  <= 1'b0;
         idx_reg         <= '0;
         notes_reg       <= '0;
         cur_hit_reg     <= '0;
         cur_lane_reg    <= '0;
         cur_type_reg    <= '0;
         spawn_valid_reg <= 1'b0;
         chart_done_reg  <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         new_frame_q_reg <= new_frame;

         // outputs decoded from the next state so they change with the state
         spawn_valid_reg <= (state_next == S_EMIT);
         chart_done_reg  <= (state_next == S_DONE);
         busy_reg        <= (state_next != S_IDLE) && (state_next != S_DONE);

         if (restart) begin
            idx_reg        <= '0;
            notes_reg      <= '0;
            ft_reg         <= '0;
            have_frame_reg <= 1'b0;
         end else begin
            // frame edges are not queued: only the latest frame is kept
            if ((state_reg != S_IDLE) && fe) begin
               ft_reg         <= un_time;
               have_frame_reg <= 1'b1;
            end
            // a handshake coinciding with stop_sign is still counted
            if (handshake) begin
               idx_reg   <= idx_reg + 1'b1;
               notes_reg <= notes_reg + 1'b1;
            end
         end

         if (state_reg == S_LOAD) begin
            cur_hit_reg  <= rom_data[19:4];
            cur_lane_reg <= rom_data[3:2];
            cur_type_reg <= rom_data[1:0];
         end
      end
   end

   // idx is 0 in IDLE, so the address reads 0 there
   assign rom_addr       = idx_reg;
   assign spawn_valid    = spawn_valid_reg;
   assign spawn_hit_time = cur_hit_reg;
   assign spawn_lane     = cur_lane_reg;
   assign spawn_type     = cur_type_reg;
   assign notes_spawned  = notes_reg;
   assign chart_done     = chart_done_reg;
   assign busy           = busy_reg;

endmodule

// File: tb/tb_note_spawn_scheduler.sv
module tb_note_spawn_scheduler;

   localparam int ADDR_W    = 10;
   localparam int FRAME_CYC = 20;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_sign;
   logic              new_frame;
   logic [15:0]       un_time;
   logic              stop_sign;
   logic [ADDR_W-1:0] rom_addr;
   logic [19:0]       rom_data;
   logic              spawn_valid;
   logic              spawn_ready;
   logic [15:0]       spawn_hit_time;
   logic [1:0]        spawn_lane;
   logic [1:0]        spawn_type;
   logic [ADDR_W:0]   notes_spawned;
   logic              chart_done;
   logic              busy;

   always #5 clk = ~clk;

   note_spawn_scheduler #(
      .LEAD_FRAMES(120),
      .ADDR_W     (ADDR_W),
      .MAX_NOTES  (1023)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start_sign    (start_sign),
      .new_frame     (new_frame),
      .un_time       (un_time),
      .stop_sign     (stop_sign),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .spawn_valid   (spawn_valid),
      .spawn_ready   (spawn_ready),
      .spawn_hit_time(spawn_hit_time),
      .spawn_lane    (spawn_lane),
      .spawn_type    (spawn_type),
      .notes_spawned (notes_spawned),
      .chart_done    (chart_done),
      .busy          (busy)
   );

   // chart ROM model with 1-cycle registered read
   logic [19:0] rom_mem [0:1023];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   typedef struct {
      logic [15:0] hit;
      logic [1:0]  lane;
      logic [1:0]  typ;
      int          frame;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cur_frame    = 0;
   bit   gap_en       = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard monitor: compares every accepted spawn, and the valid gap
   int   cyc = 0;
   int   last_hs = 0;
   bit   hs_seen = 1'b0;
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      cyc        <= cyc + 1;
      prev_valid <= spawn_valid;
      if (!gap_en) hs_seen <= 1'b0;
      if (reset && gap_en && hs_seen && spawn_valid && !prev_valid)
         check_val("valid_gap", 32'(cyc - last_hs), 32'd5);
      if (reset && spawn_valid && spawn_ready) begin
         last_hs <= cyc;
         if (gap_en) hs_seen <= 1'b1;
         if (sb_q.size() == 0) begin
            check_val("sb_unexpected_spawn", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("spawn_hit", 32'(spawn_hit_time), 32'(e.hit));
            check_val("spawn_lane", 32'(spawn_lane), 32'(e.lane));
            check_val("spawn_type", 32'(spawn_type), 32'(e.typ));
            check_val("spawn_frame", 32'(cur_frame), 32'(e.frame));
            $display("[TB] spawn hit=%0d lane=%0d type=%0d frame=%0d count=%0d",
                     spawn_hit_time, spawn_lane, spawn_type, cur_frame, notes_spawned);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input int t);
      cur_frame = t;
      un_time   = 16'(t);
      new_frame = 1'b1;
      tick(3);
      new_frame = 1'b0;
      tick(FRAME_CYC - 3);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom_mem[i] = 20'hFFFF0;
   endtask

   task automatic set_note(input int i, input int hit, input int lane, input int typ);
      rom_mem[i] = {16'(hit), 2'(lane), 2'(typ)};
   endtask

   task automatic push_exp(input int hit, input int lane, input int typ, input int fr);
      exp_t e;
      e.hit = 16'(hit); e.lane = 2'(lane); e.typ = 2'(typ); e.frame = fr;
      sb_q.push_back(e);
   endtask

   task automatic start_song();
      start_sign = 1'b1;
      tick(1);
      start_sign = 1'b0;
      tick(7);
   endtask

   initial begin
      reset = 1'b0; start_sign = 1'b0; new_frame = 1'b0; un_time = '0;
      stop_sign = 1'b0; spawn_ready = 1'b0;
      clear_rom();
      tick(3);
      check_val("rst_valid", 32'(spawn_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(chart_done), 32'd0);
      check_val("rst_addr", 32'(rom_addr), 32'd0);
      reset = 1'b1;
      tick(2);

      // basic chart
      clear_rom();
      set_note(0, 130, 1, 0);
      set_note(1, 200, 2, 1);
      push_exp(130, 1, 0, 10);
      push_exp(200, 2, 1, 80);
      spawn_ready = 1'b1;
      start_song();
      check_val("t2_busy", 32'(busy), 32'd1);
      for (int t = 0; t < 200 && !chart_done; t++) frame(t);
      check_val("t2_done", 32'(chart_done), 32'd1);
      check_val("t2_count", 32'(notes_spawned), 32'd2);
      check_val("t2_addr", 32'(rom_addr), 32'd2);
      check_val("t2_sb_empty", 32'(sb_q.size()), 32'd0);

      // same-frame burst
      clear_rom();
      set_note(0, 300, 0, 0);
      set_note(1, 300, 1, 2);
      set_note(2, 300, 3, 3);
      push_exp(300, 0, 0, 180);
      push_exp(300, 1, 2, 180);
      push_exp(300, 3, 3, 180);
      gap_en = 1'b1;
      start_song();
      for (int t = 0; t < 300 && !chart_done; t++) frame(t);
      gap_en = 1'b0;
      check_val("t3_done", 32'(chart_done), 32'd1);
      check_val("t3_count", 32'(notes_spawned), 32'd3);
      check_val("t3_sb_empty", 32'(sb_q.size()), 32'd0);

      // backpressure
      clear_rom();
      set_note(0, 130, 2, 3);
      spawn_ready = 1'b0;
      start_song();
      for (int t = 0; t < 40 && !spawn_valid; t++) frame(t);
      check_val("t4_frame", 32'(cur_frame), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check_val("t4_hold_valid", 32'(spawn_valid), 32'd1);
         check_val("t4_hold_hit", 32'(spawn_hit_time), 32'd130);
         check_val("t4_hold_lane", 32'(spawn_lane), 32'd2);
         check_val("t4_hold_type", 32'(spawn_type), 32'd3);
         tick(1);
      end
      check_val("t4_count_stalled", 32'(notes_spawned), 32'd0);
      push_exp(130, 2, 3, 10);
      spawn_ready = 1'b1;
      tick(1);
      check_val("t4_count_one", 32'(notes_spawned), 32'd1);
      tick(8);
      check_val("t4_count_final", 32'(notes_spawned), 32'd1);
      check_val("t4_done", 32'(chart_done), 32'd1);

      // early note, then a late note after a long stall
      clear_rom();
      set_note(0, 50, 0, 1);
      set_note(1, 140, 1, 0);
      spawn_ready = 1'b0;
      gap_en = 1'b1;
      start_song();
      frame(0);
      check_val("t5_early_valid", 32'(spawn_valid), 32'd1);
      check_val("t5_early_hit", 32'(spawn_hit_time), 32'd50);
      for (int t = 1; t <= 40; t++) frame(t);
      push_exp(50, 0, 1, 40);
      push_exp(140, 1, 0, 40);
      spawn_ready = 1'b1;
      tick(12);
      gap_en = 1'b0;
      check_val("t5_count", 32'(notes_spawned), 32'd2);
      check_val("t5_done", 32'(chart_done), 32'd1);
      check_val("t5_sb_empty", 32'(sb_q.size()), 32'd0);

      // stop during a stalled EMIT, then replay
      clear_rom();
      set_note(0, 130, 1, 1);
      set_note(1, 200, 2, 2);
      spawn_ready = 1'b0;
      start_song();
      for (int t = 0; t < 40 && !spawn_valid; t++) frame(t);
      check_val("t6_frame", 32'(cur_frame), 32'd10);
      stop_sign = 1'b1;
      tick(1);
      stop_sign = 1'b0;
      check_val("t6_stop_valid", 32'(spawn_valid), 32'd0);
      check_val("t6_stop_done", 32'(chart_done), 32'd1);
      check_val("t6_stop_busy", 32'(busy), 32'd0);
      check_val("t6_stop_count", 32'(notes_spawned), 32'd0);
      start_sign = 1'b1;
      tick(1);
      start_sign = 1'b0;
      check_val("t6_restart_addr", 32'(rom_addr), 32'd0);
      check_val("t6_restart_busy", 32'(busy), 32'd1);
      push_exp(130, 1, 1, 10);
      push_exp(200, 2, 2, 80);
      spawn_ready = 1'b1;
      tick(6);
      for (int t = 0; t < 200 && !chart_done; t++) frame(t);
      check_val("t6_replay_count", 32'(notes_spawned), 32'd2);
      check_val("t6_sb_empty", 32'(sb_q.size()), 32'd0);

      // reset held mid-EMIT
      clear_rom();
      set_note(0, 130, 3, 2);
      spawn_ready = 1'b0;
      start_song();
      for (int t = 0; t < 40 && !spawn_valid; t++) frame(t);
      check_val("t1_pre_valid", 32'(spawn_valid), 32'd1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_val("t1_rst_valid", 32'(spawn_valid), 32'd0);
         check_val("t1_rst_addr", 32'(rom_addr), 32'd0);
         check_val("t1_rst_count", 32'(notes_spawned), 32'd0);
         check_val("t1_rst_busy", 32'(busy), 32'd0);
         check_val("t1_rst_done", 32'(chart_done), 32'd0);
      end
      reset = 1'b1;
      spawn_ready = 1'b1;
      for (int t = 20; t < 23; t++) frame(t);
      check_val("t1_idle_busy", 32'(busy), 32'd0);
      check_val("t1_idle_done", 32'(chart_done), 32'd0);
      check_val("t1_idle_valid", 32'(spawn_valid), 32'd0);
      check_val("t1_idle_count", 32'(notes_spawned), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
